serial_adder: RTL

//   Bit-serial WIDTH-bit adder built around a single 1-bit full-adder cell and
//   a registered carry. It processes one bit per clock, LSB first.
//   It sits downstream of the ha/fa cell library as the area-cheap alternative
//   to a ripple-carry chain. A start/busy/done handshake delivers operands and

---
 rtl/serial_adder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder. A single 1-bit full-adder cell and a
//            registered carry process one operand bit per clock, LSB first.
//            A start/busy/done handshake delivers operands and returns the
//            result. It is the area-cheap alternative to a ripple-carry chain.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  operand/result width in bits (1..64)
// Ports
//   clk    in   1      clock, all state changes on the rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request; honoured only in IDLE or DONE
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   cin    in   1      carry-in, captured on the accepted start edge
//   busy   out  1      high while the add is running
//   done   out  1      one-cycle pulse, sum/cout valid
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered carry-out, held until the next completion
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Counter holds 0..WIDTH-1; one spare bit keeps the width sane at WIDTH=1.
   localparam int            C_CW   = $clog2(WIDTH) + 1;
   localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_load;
   logic              w_step;
   logic              w_last;

   logic [WIDTH-1:0]  r_a_sh;
   logic [WIDTH-1:0]  r_b_sh;
   logic              r_c;
   logic [C_CW-1:0]   r_cnt;

   logic              w_p;
   logic              w_s_bit;
   logic              w_c_nxt;
   logic [WIDTH-1:0]  w_s_nxt;

   // ------------------------------------------------------------------------
   // FSM: state register (also registers busy/done from the next state so
   // that both outputs come straight from flops).
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         busy    <= (w_state_nxt == S_RUN);
         done    <= (w_state_nxt == S_DONE);
      end
   end

   // FSM: next-state and datapath control
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_last      = (r_cnt == C_LAST);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_load      = 1'b1;
            end
         end
         S_RUN: begin
            // start is deliberately not looked at here: it is not queued.
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // The single full-adder cell working on the operand LSBs.
   // ------------------------------------------------------------------------
   assign w_p     = r_a_sh[0] ^ r_b_sh[0];
   assign w_s_bit = w_p ^ r_c;
   assign w_c_nxt = (r_a_sh[0] & r_b_sh[0]) | (r_c & w_p);

   // ------------------------------------------------------------------------
   // Partial-sum shift register. Sum bits enter at the top and move down, so
   // only WIDTH-1 bits need storing: the final bit is taken straight from the
   // cell on the completing edge. At WIDTH=1 no storage is needed at all.
   // ------------------------------------------------------------------------
   generate
      if (WIDTH > 1) begin : g_sum_sh
         logic [WIDTH-2:0] r_s_sh;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_s_sh <= '0;
            end else if (w_load) begin
               r_s_sh <= '0;
            end else if (w_step) begin
               r_s_sh <= w_s_nxt[WIDTH-1:1];
            end
         end

         assign w_s_nxt = {w_s_bit, r_s_sh};
      end else begin : g_sum_bit
         assign w_s_nxt = w_s_bit;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Operand shifters, carry, bit counter and result registers.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh <= '0;
         r_b_sh <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else if (w_load) begin
         r_a_sh <= a;
         r_b_sh <= b;
         r_c    <= cin;
         r_cnt  <= '0;
      end else if (w_step) begin
         r_a_sh <= r_a_sh >> 1;
         r_b_sh <= r_b_sh >> 1;
         r_c    <= w_c_nxt;
         r_cnt  <= r_cnt + C_CW'(1);
         // Result registers move only on the completing edge, so a new run
         // leaves the previous result visible until it finishes.
         if (w_last) begin
            sum  <= w_s_nxt;
            cout <= w_c_nxt;
         end
      end
   end

endmodule
`default_nettype wire
